// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words from imem (one request in flight at most)
// and hands {instr, pc} to decode with a one-entry hold buffer and redirect/squash support.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | request for pc presented to imem, waiting for accept
// WAIT  | request accepted, waiting for the response word
// HOLD  | response parked in the hold buffer while decode stalls
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        slot_free;

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_instr      = out_instr_q;
    assign out_pc         = out_pc_q;
    assign slot_free      = !out_valid_q || out_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        kill_d       = kill_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d    = S_WAIT;
                    pc_d       = pc_q + 32'd4;
                    fetch_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (slot_free) begin
                        out_instr_d = imem_resp_data;
                        out_pc_d    = fetch_pc_q;
                        out_valid_d = 1'b1;
                        state_d     = S_REQ;
                    end else begin
                        hold_instr_d = imem_resp_data;
                        hold_pc_d    = fetch_pc_q;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_instr_d = hold_instr_q;
                    out_pc_d    = hold_pc_q;
                    out_valid_d = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over everything above; an accepted or in-flight fetch is marked killed.
        if (redirect_valid) begin
            pc_d         = redirect_pc & ~32'h3;
            out_valid_d  = 1'b0;
            hold_instr_d = 32'h0;
            hold_pc_d    = 32'h0;
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            kill_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0;
            out_pc_q     <= 32'h0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            kill_q       <= kill_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetched instruction stream.
module tb_instruction_fetch_unit;

    localparam logic [31:0] PC_A = 32'h0000_0000;
    localparam logic [31:0] PC_B = 32'hFFFF_FFF8;

    logic        CLK;
    logic        RESET;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        b_reset;
    logic        b_req_valid;
    logic [31:0] b_req_addr;
    logic        b_req_ready;
    logic        b_resp_valid;
    logic [31:0] b_resp_data;
    logic        b_out_valid;
    logic [31:0] b_out_instr;
    logic [31:0] b_out_pc;
    logic        b_out_ready;
    logic        b_redirect_valid;
    logic [31:0] b_redirect_pc;

    instruction_fetch_unit #(.RESET_PC(PC_A)) dut_a (
        .CLK(CLK), .RESET(RESET),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_ready(out_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    instruction_fetch_unit #(.RESET_PC(PC_B)) dut_b (
        .CLK(CLK), .RESET(b_reset),
        .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
        .imem_req_ready(b_req_ready), .imem_resp_valid(b_resp_valid),
        .imem_resp_data(b_resp_data), .out_valid(b_out_valid), .out_instr(b_out_instr),
        .out_pc(b_out_pc), .out_ready(b_out_ready), .redirect_valid(b_redirect_valid),
        .redirect_pc(b_redirect_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          lat      = 1;
    bit          rand_lat = 0;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic [31:0] exp_pc   = PC_A;
    logic [31:0] qb_pc[$];
    logic [31:0] qb_instr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h00A0_0113;
            default:       mem_word = a ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: capture handshakes before the edge, then advance the imem models and the
    // expected-stream model.
    task automatic tick();
        logic        p_rst, p_fire, p_ofire, p_stall, p_redir, p_resp;
        logic        pb_rst, pb_fire, pb_ofire;
        logic [31:0] p_addr, p_target, p_opc, p_oinstr, pb_addr;
        p_rst    = RESET;
        p_fire   = imem_req_valid && imem_req_ready;
        p_addr   = imem_req_addr;
        p_resp   = imem_resp_valid;
        p_redir  = redirect_valid;
        p_target = redirect_pc & ~32'h3;
        p_ofire  = out_valid && out_ready;
        p_stall  = out_valid && !out_ready;
        p_opc    = out_pc;
        p_oinstr = out_instr;
        pb_rst   = b_reset;
        pb_fire  = b_req_valid && b_req_ready;
        pb_addr  = b_req_addr;
        pb_ofire = b_out_valid && b_out_ready;
        if (!pb_rst && pb_ofire) begin
            qb_pc.push_back(b_out_pc);
            qb_instr.push_back(b_out_instr);
        end

        @(posedge CLK);
        #1;

        if (p_rst) begin
            pend = 1'b0;
        end else if (p_fire) begin
            check("one_outstanding", {31'b0, pend}, 32'h0);
            check("addr_align", {30'b0, p_addr[1:0]}, 32'h0);
            pend      = 1'b1;
            pend_addr = p_addr;
            pend_cnt  = (rand_lat ? $urandom_range(1, 4) : lat) - 1;
        end else if (pend && p_resp) begin
            pend = 1'b0;
        end else if (pend) begin
            pend_cnt--;
        end
        imem_resp_valid = pend && (pend_cnt == 0);
        imem_resp_data  = imem_resp_valid ? mem_word(pend_addr) : 32'h0;

        b_resp_valid = !pb_rst && pb_fire;
        b_resp_data  = mem_word(pb_addr);

        if (p_rst) begin
            exp_pc = PC_A;
        end else begin
            if (p_ofire && !p_redir) begin
                check("sb_pc", p_opc, exp_pc);
                check("sb_instr", p_oinstr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_out++;
            end
            if (p_redir) begin
                exp_pc = p_target;
                check("redir_squash", {31'b0, out_valid}, 32'h0);
            end else if (p_stall) begin
                check("stall_valid", {31'b0, out_valid}, 32'h1);
                check("stall_pc", out_pc, p_opc);
                check("stall_instr", out_instr, p_oinstr);
            end
        end
    endtask

    task automatic reset_a(input string tag);
        RESET          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        tick();
        check({tag, "_rst_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        check({tag, "_rst_req_addr"}, imem_req_addr, PC_A);
        check({tag, "_rst_out_valid"}, {31'b0, out_valid}, 32'h0);
        check({tag, "_rst_out_instr"}, out_instr, 32'h0);
        check({tag, "_rst_out_pc"}, out_pc, 32'h0);
        RESET = 1'b0;
    endtask

    initial begin
        bit          found;
        int          n_before;
        logic [31:0] got_pc, got_instr;

        RESET            = 1'b1;
        imem_req_ready   = 1'b1;
        imem_resp_valid  = 1'b0;
        imem_resp_data   = 32'h0;
        out_ready        = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        b_reset          = 1'b1;
        b_req_ready      = 1'b1;
        b_resp_valid     = 1'b0;
        b_resp_data      = 32'h0;
        b_out_ready      = 1'b1;
        b_redirect_valid = 1'b0;
        b_redirect_pc    = 32'h0;

        // Basic stream with a 1-cycle memory
        lat = 1;
        reset_a("t1");
        b_reset = 1'b0;
        check("t1_idle_noreq", {31'b0, imem_req_valid}, 32'h0);
        tick();
        check("t1_req0_valid", {31'b0, imem_req_valid}, 32'h1);
        check("t1_req0_addr", imem_req_addr, 32'h0);
        tick();
        check("t1_wait_noreq", {31'b0, imem_req_valid}, 32'h0);
        check("t1_wait_noout", {31'b0, out_valid}, 32'h0);
        tick();
        check("t1_out0_valid", {31'b0, out_valid}, 32'h1);
        check("t1_out0_pc", out_pc, 32'h0);
        check("t1_out0_instr", out_instr, 32'h0050_0093);
        check("t1_req4_addr", imem_req_addr, 32'h4);
        check("t1_req4_valid", {31'b0, imem_req_valid}, 32'h1);
        tick();
        check("t1_gap_noout", {31'b0, out_valid}, 32'h0);
        tick();
        check("t1_out1_valid", {31'b0, out_valid}, 32'h1);
        check("t1_out1_pc", out_pc, 32'h4);
        check("t1_out1_instr", out_instr, 32'h00A0_0113);
        check("t1_req8_addr", imem_req_addr, 32'h8);

        // Decode backpressure into the hold buffer
        reset_a("t2");
        tick(); tick(); tick();
        check("t2_first_pc", out_pc, 32'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_hold_valid", {31'b0, out_valid}, 32'h1);
            check("t2_hold_pc", out_pc, 32'h0);
            check("t2_hold_noreq", {31'b0, imem_req_valid}, 32'h0);
        end
        out_ready = 1'b1;
        tick();
        check("t2_release_valid", {31'b0, out_valid}, 32'h1);
        check("t2_release_pc", out_pc, 32'h4);
        check("t2_next_req", {31'b0, imem_req_valid}, 32'h1);
        check("t2_next_addr", imem_req_addr, 32'h8);

        // Redirect while waiting on a slow memory for pc 8
        lat = 3;
        reset_a("t3");
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (imem_req_valid && imem_req_addr == 32'h8) found = 1;
            else tick();
        end
        check("t3_reached_req8", {31'b0, found}, 32'h1);
        tick();
        check("t3_in_wait", {31'b0, imem_req_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        found     = 0;
        got_pc    = 32'h0;
        got_instr = 32'h0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid) begin
                found     = 1;
                got_pc    = out_pc;
                got_instr = out_instr;
            end else begin
                tick();
            end
        end
        check("t3_got_out", {31'b0, found}, 32'h1);
        check("t3_out_pc", got_pc, 32'h100);
        check("t3_out_instr", got_instr, mem_word(32'h100));

        // Redirect in the same cycle as the response
        lat = 1;
        reset_a("t4");
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        check("t4_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("t4_req_addr", imem_req_addr, 32'h200);
        check("t4_dropped", {31'b0, out_valid}, 32'h0);
        tick(); tick();
        check("t4_out_valid", {31'b0, out_valid}, 32'h1);
        check("t4_out_pc", out_pc, 32'h200);
        check("t4_out_instr", out_instr, mem_word(32'h200));

        // Reset while a word sits in the hold buffer
        reset_a("t6");
        tick(); tick(); tick();
        out_ready = 1'b0;
        tick(); tick();
        check("t6_hold_valid", {31'b0, out_valid}, 32'h1);
        check("t6_hold_noreq", {31'b0, imem_req_valid}, 32'h0);
        RESET = 1'b1;
        tick();
        check("t6_rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("t6_rst_out_pc", out_pc, 32'h0);
        check("t6_rst_out_instr", out_instr, 32'h0);
        RESET     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("t6_req_addr", imem_req_addr, PC_A);
        tick(); tick();
        check("t6_out_valid", {31'b0, out_valid}, 32'h1);
        check("t6_out_pc", out_pc, PC_A);

        // Randomized traffic against the stream model
        reset_a("rnd");
        rand_lat = 1;
        n_before = n_out;
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(0, 99) < 65);
            imem_req_ready = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc    = ($urandom_range(0, 1) == 0) ? $urandom()
                                                         : (32'hFFFF_FFF0 | $urandom_range(0, 15));
            RESET          = ($urandom_range(0, 999) < 4);
            tick();
        end
        RESET          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        tick(); tick();
        check("rnd_progress", {31'b0, (n_out - n_before) >= 100}, 32'h1);

        // Wrap-around stream from the second instance
        check("t5_count", {31'b0, qb_pc.size() >= 3}, 32'h1);
        if (qb_pc.size() >= 3) begin
            check("t5_pc0", qb_pc[0], 32'hFFFF_FFF8);
            check("t5_pc1", qb_pc[1], 32'hFFFF_FFFC);
            check("t5_pc2", qb_pc[2], 32'h0000_0000);
            check("t5_instr2", qb_instr[2], mem_word(32'h0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
